// File: rtl/mfm_sector_reader_if.sv
// mfm_sector_reader_if: decoder, command and data-out signals of the MFM sector reader.
interface mfm_sector_reader_if;
    logic       start;
    logic       abort;
    logic [7:0] target_c;
    logic [7:0] target_h;
    logic [7:0] target_r;
    logic       dec_enable;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       am_detected;
    logic [1:0] am_type;
    logic       index_pulse;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic [1:0] size_n;
    logic       deleted;
    logic       busy;
    logic       done;
    logic [2:0] status;

    modport master (
        output start, abort, target_c, target_h, target_r,
        output byte_in, byte_valid, am_detected, am_type, index_pulse,
        input  dec_enable, out_data, out_valid, out_last, size_n, deleted, busy, done, status
    );

    modport slave (
        input  start, abort, target_c, target_h, target_r,
        input  byte_in, byte_valid, am_detected, am_type, index_pulse,
        output dec_enable, out_data, out_valid, out_last, size_n, deleted, busy, done, status
    );
endinterface

// File: rtl/mfm_sector_reader.sv
// mfm_sector_reader: finds the ID matching C/H/R, streams the following data field out.
// Define FLUXRIPPER_SECTOR_CRC_EN to include the CRC-16-CCITT field checks.
module mfm_sector_reader #(
    parameter int MAX_N       = 3,
    parameter int DAM_TIMEOUT = 43,
    parameter int INDEX_LIMIT = 2
) (
    input logic               clk,
    input logic               reset,
    mfm_sector_reader_if.slave bus
);
    typedef enum logic [2:0] {IDLE, WAIT_IDAM, ID_FIELD, WAIT_DAM, DATA_FIELD, DATA_CRC, DONE} state_t;

    localparam logic [7:0] GAP_LIM = 8'(DAM_TIMEOUT);
    localparam logic [7:0] IDX_LIM = 8'(INDEX_LIMIT);
    localparam logic [7:0] N_MAX   = 8'(MAX_N);

    state_t     state_q, state_d;
    logic [7:0] tc_q, tc_d, th_q, th_d, tr_q, tr_d;
    logic [7:0] idc_q, idc_d, idh_q, idh_d, idr_q, idr_d, idn_q, idn_d;
    logic [9:0] byte_cnt_q, byte_cnt_d;
    logic [7:0] gap_cnt_q, gap_cnt_d, index_cnt_q, index_cnt_d;
    logic [1:0] size_q, size_d;
    logic       del_q, del_d;
    logic [2:0] status_q, status_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic       busy, crc_ok, last, id_match;
    logic [10:0] last_idx;
    logic [7:0] idx_inc;

`ifdef FLUXRIPPER_SECTOR_CRC_EN
    logic [15:0] crc_q, crc_d, crc_nx;

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) r = r[15] ? {r[14:0], 1'b0} ^ 16'h1021 : {r[14:0], 1'b0};
        return r;
    endfunction

    // Address marks inside the data field are ignored, so they must not re-preset the CRC either
    assign crc_nx = crc_byte((bus.am_detected && state_q != DATA_FIELD && state_q != DATA_CRC)
                             ? 16'hCDB4 : crc_q, bus.byte_in);
    assign crc_d  = bus.byte_valid ? crc_nx : crc_q;
    assign crc_ok = crc_nx == 16'h0000;

    always_ff @(posedge clk) crc_q <= reset ? 16'h0000 : crc_d;
`else
    assign crc_ok = 1'b1;
`endif

    assign busy     = state_q != IDLE && state_q != DONE;
    assign last_idx = (11'd128 << size_q) - 11'd1;
    assign last     = {1'b0, byte_cnt_q} == last_idx;
    assign idx_inc  = index_cnt_q + 8'd1;
    assign id_match = idc_q == tc_q && idh_q == th_q && idr_q == tr_q && idn_q <= N_MAX && crc_ok;

    always_comb begin
        state_d     = state_q;
        tc_d        = tc_q;
        th_d        = th_q;
        tr_d        = tr_q;
        idc_d       = idc_q;
        idh_d       = idh_q;
        idr_d       = idr_q;
        idn_d       = idn_q;
        byte_cnt_d  = byte_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        index_cnt_d = index_cnt_q;
        size_d      = size_q;
        del_d       = del_q;
        status_d    = status_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        if (bus.abort && busy) begin
            state_d  = DONE;
            status_d = 3'd4;
        end else begin
            case (state_q)
                IDLE: if (bus.start && !bus.abort) begin
                    state_d     = WAIT_IDAM;
                    tc_d        = bus.target_c;
                    th_d        = bus.target_h;
                    tr_d        = bus.target_r;
                    del_d       = 1'b0;
                    size_d      = 2'd0;
                    status_d    = 3'd0;
                    index_cnt_d = 8'd0;
                end
                WAIT_IDAM, ID_FIELD: begin
                    if (bus.index_pulse) index_cnt_d = idx_inc;
                    if (bus.index_pulse && idx_inc >= IDX_LIM) begin
                        state_d  = DONE;
                        status_d = 3'd1;
                    end else if (bus.am_detected) begin
                        state_d    = bus.am_type == 2'b01 ? ID_FIELD : WAIT_IDAM;
                        byte_cnt_d = 10'd0;
                    end else if (state_q == ID_FIELD && bus.byte_valid) begin
                        byte_cnt_d = byte_cnt_q + 10'd1;
                        idc_d      = byte_cnt_q == 10'd0 ? bus.byte_in : idc_q;
                        idh_d      = byte_cnt_q == 10'd1 ? bus.byte_in : idh_q;
                        idr_d      = byte_cnt_q == 10'd2 ? bus.byte_in : idr_q;
                        idn_d      = byte_cnt_q == 10'd3 ? bus.byte_in : idn_q;
                        if (byte_cnt_q == 10'd5) begin
                            state_d   = id_match ? WAIT_DAM : WAIT_IDAM;
                            size_d    = id_match ? idn_q[1:0] : size_q;
                            gap_cnt_d = 8'd0;
                        end
                    end
                end
                WAIT_DAM: begin
                    if (bus.am_detected && bus.am_type[1]) begin
                        state_d    = DATA_FIELD;
                        del_d      = bus.am_type[0];
                        byte_cnt_d = 10'd0;
                    end else if (bus.am_detected && bus.am_type == 2'b01) begin
                        state_d  = DONE;
                        status_d = 3'd2;
                    end else if (bus.byte_valid) begin
                        gap_cnt_d = gap_cnt_q + 8'd1;
                        state_d   = gap_cnt_d == GAP_LIM ? DONE : WAIT_DAM;
                        status_d  = gap_cnt_d == GAP_LIM ? 3'd2 : status_q;
                    end
                end
                DATA_FIELD: if (bus.byte_valid) begin
                    out_valid_d = 1'b1;
                    out_data_d  = bus.byte_in;
                    out_last_d  = last;
                    byte_cnt_d  = last ? 10'd0 : byte_cnt_q + 10'd1;
                    state_d     = last ? DATA_CRC : DATA_FIELD;
                end
                DATA_CRC: if (bus.byte_valid) begin
                    byte_cnt_d = byte_cnt_q + 10'd1;
                    if (byte_cnt_q == 10'd1) begin
                        state_d  = DONE;
                        status_d = crc_ok ? 3'd0 : 3'd3;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            tc_q        <= 8'd0;
            th_q        <= 8'd0;
            tr_q        <= 8'd0;
            idc_q       <= 8'd0;
            idh_q       <= 8'd0;
            idr_q       <= 8'd0;
            idn_q       <= 8'd0;
            byte_cnt_q  <= 10'd0;
            gap_cnt_q   <= 8'd0;
            index_cnt_q <= 8'd0;
            size_q      <= 2'd0;
            del_q       <= 1'b0;
            status_q    <= 3'd0;
            out_data_q  <= 8'd0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tc_q        <= tc_d;
            th_q        <= th_d;
            tr_q        <= tr_d;
            idc_q       <= idc_d;
            idh_q       <= idh_d;
            idr_q       <= idr_d;
            idn_q       <= idn_d;
            byte_cnt_q  <= byte_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            index_cnt_q <= index_cnt_d;
            size_q      <= size_d;
            del_q       <= del_d;
            status_q    <= status_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.dec_enable = busy;
    assign bus.busy       = busy;
    assign bus.done       = state_q == DONE;
    assign bus.out_data   = out_data_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_last   = out_last_q;
    assign bus.size_n     = size_q;
    assign bus.deleted    = del_q;
    assign bus.status     = status_q;
endmodule

// File: tb/tb_mfm_sector_reader.sv
// tb_mfm_sector_reader: directed sector-read scenarios checked through data and completion scoreboards.
module tb_mfm_sector_reader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    logic [8:0] dq[$];
    logic [6:0] fq[$];

`ifdef FLUXRIPPER_SECTOR_CRC_EN
    localparam logic [2:0] ST_BADCRC = 3'd3;
`else
    localparam logic [2:0] ST_BADCRC = 3'd0;
`endif

    mfm_sector_reader_if bus();
    mfm_sector_reader dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] crc(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) r = {r[14:0], 1'b0} ^ ((r[15] ^ b[i]) ? 16'h1021 : 16'h0000);
        return r;
    endfunction

    always @(negedge clk) begin
        if (!reset && bus.out_valid) begin
            if (dq.size() == 0) chk("spurious_out_valid", 32'd1, 32'd0);
            else chk("data", {bus.out_last, bus.out_data}, dq.pop_front());
        end
        if (!reset && bus.done) begin
            done_cnt++;
            if (fq.size() == 0) chk("spurious_done", 32'd1, 32'd0);
            else chk("done_status_size_del_busy", {bus.status, bus.size_n, bus.deleted, bus.busy}, fq.pop_front());
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] b, input logic am, input logic [1:0] t);
        bus.byte_in = b;
        bus.byte_valid = 1'b1;
        bus.am_detected = am;
        bus.am_type = t;
        cyc();
        bus.byte_valid = 1'b0;
        bus.am_detected = 1'b0;
        bus.am_type = 2'b00;
        cyc();
    endtask

    task automatic gap(input int k);
        repeat (k) put(8'h4E, 1'b0, 2'b00);
    endtask

    task automatic pulse();
        bus.index_pulse = 1'b1;
        cyc();
        bus.index_pulse = 1'b0;
        cyc();
    endtask

    task automatic start_rd(input logic [7:0] c, input logic [7:0] h, input logic [7:0] r);
        bus.target_c = c;
        bus.target_h = h;
        bus.target_r = r;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic send_id(input logic [7:0] c, input logic [7:0] h, input logic [7:0] r, input logic [7:0] n);
        logic [15:0] cs;
        cs = crc(crc(crc(crc(16'hFFFF, 8'hA1), 8'hA1), 8'hA1), 8'hFE);
        cs = crc(crc(crc(crc(cs, c), h), r), n);
        put(8'hFE, 1'b1, 2'b01);
        put(c, 1'b0, 2'b00);
        put(h, 1'b0, 2'b00);
        put(r, 1'b0, 2'b00);
        put(n, 1'b0, 2'b00);
        put(cs[15:8], 1'b0, 2'b00);
        put(cs[7:0], 1'b0, 2'b00);
    endtask

    task automatic send_data(input logic [1:0] t, input int len, input int cnt, input bit flip);
        logic [15:0] cs;
        logic [7:0] am, b;
        am = t == 2'b11 ? 8'hF8 : 8'hFB;
        cs = crc(crc(crc(crc(16'hFFFF, 8'hA1), 8'hA1), 8'hA1), am);
        put(am, 1'b1, t);
        for (int i = 0; i < cnt; i++) begin
            b = 8'(i);
            cs = crc(cs, b);
            if (flip && i == len - 1) b = b ^ 8'h01;
            dq.push_back({i == len - 1, b});
            put(b, 1'b0, 2'b00);
        end
        if (cnt == len) begin
            put(cs[15:8], 1'b0, 2'b00);
            put(cs[7:0], 1'b0, 2'b00);
        end
    endtask

    task automatic wait_done(input string name, input int d0);
        for (int n = 0; n < 4000 && done_cnt == d0; n++) cyc();
        chk(name, done_cnt - d0, 32'd1);
    endtask

    task automatic run_s1(input string tag);
        int d0;
        d0 = done_cnt;
        fq.push_back({3'd0, 2'd2, 1'b0, 1'b0});
        start_rd(8'h02, 8'h01, 8'h05);
        chk({tag, "_busy_en"}, {bus.busy, bus.dec_enable}, 2'b11);
        gap(5);
        send_id(8'h02, 8'h01, 8'h05, 8'h02);
        gap(20);
        send_data(2'b10, 512, 512, 1'b0);
        wait_done({tag, "_done"}, d0);
        cyc();
        chk({tag, "_hold"}, {bus.status, bus.size_n, bus.deleted, bus.busy, bus.dec_enable}, {3'd0, 2'd2, 3'b000});
    endtask

    initial begin
        int d0;
        {bus.start, bus.abort, bus.byte_valid, bus.am_detected, bus.index_pulse} = '0;
        {bus.target_c, bus.target_h, bus.target_r, bus.byte_in, bus.am_type} = '0;
        repeat (3) cyc();
        chk("reset_outputs", {bus.dec_enable, bus.out_data, bus.out_valid, bus.out_last, bus.size_n,
                              bus.deleted, bus.busy, bus.done, bus.status}, 32'd0);
        reset = 1'b0;
        cyc();
        bus.start = 1'b1;
        bus.abort = 1'b1;
        cyc();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        cyc();
        chk("start_with_abort_ignored", {bus.busy, bus.done}, 2'b00);

        run_s1("s1");

        fq.push_back({3'd1, 2'd0, 1'b0, 1'b0});
        start_rd(8'h02, 8'h01, 8'h05);
        send_id(8'h02, 8'h01, 8'h06, 8'h02);
        gap(3);
        pulse();
        chk("s2_busy_after_1st_index", bus.busy, 1'b1);
        gap(3);
        d0 = done_cnt;
        pulse();
        chk("s2_done_on_2nd_index", done_cnt - d0, 32'd1);
        pulse();
        gap(2);
        chk("s2_no_extra_done", done_cnt - d0, 32'd1);

        fq.push_back({3'd2, 2'd2, 1'b0, 1'b0});
        start_rd(8'h02, 8'h01, 8'h05);
        send_id(8'h02, 8'h01, 8'h05, 8'h02);
        d0 = done_cnt;
        gap(42);
        chk("s3_no_done_at_42", done_cnt - d0, 32'd0);
        chk("s3_busy_at_42", bus.busy, 1'b1);
        gap(1);
        chk("s3_done_at_43", done_cnt - d0, 32'd1);

        d0 = done_cnt;
        fq.push_back({ST_BADCRC, 2'd0, 1'b1, 1'b0});
        start_rd(8'h02, 8'h01, 8'h05);
        send_id(8'h02, 8'h01, 8'h05, 8'h00);
        gap(10);
        send_data(2'b11, 128, 128, 1'b1);
        wait_done("s4_done", d0);

        fq.push_back({3'd4, 2'd1, 1'b0, 1'b0});
        start_rd(8'h02, 8'h01, 8'h05);
        send_id(8'h02, 8'h01, 8'h05, 8'h01);
        gap(3);
        start_rd(8'h02, 8'h01, 8'h09);
        gap(3);
        chk("s5_start_while_busy", {bus.busy, bus.done}, 2'b10);
        d0 = done_cnt;
        send_data(2'b10, 256, 100, 1'b0);
        bus.byte_in = 8'd100;
        bus.byte_valid = 1'b1;
        bus.abort = 1'b1;
        cyc();
        bus.byte_valid = 1'b0;
        bus.abort = 1'b0;
        chk("s5_abort_done_busy", {bus.done, bus.busy, bus.dec_enable, bus.status}, {3'b100, 3'd4});
        cyc();
        chk("s5_after_abort", {bus.done, bus.busy, bus.out_valid}, 3'b000);
        chk("s5_one_done", done_cnt - d0, 32'd1);

        start_rd(8'h02, 8'h01, 8'h05);
        send_id(8'h02, 8'h01, 8'h05, 8'h02);
        gap(4);
        send_data(2'b10, 512, 50, 1'b0);
        d0 = done_cnt;
        reset = 1'b1;
        cyc();
        chk("s6_reset_outputs", {bus.dec_enable, bus.out_data, bus.out_valid, bus.out_last, bus.size_n,
                                 bus.deleted, bus.busy, bus.done, bus.status}, 32'd0);
        chk("s6_data_drained", dq.size(), 32'd0);
        reset = 1'b0;
        cyc();
        chk("s6_no_done", done_cnt - d0, 32'd0);
        run_s1("s6_reread");

        chk("queues_empty", dq.size() + fq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
